// File: rtl/hex_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_disp_pkg
//  Description : Shared constants, scan FSM encoding and helper function for
//                the time-shared HEX display sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package hex_disp_pkg;

    // Active-low pattern with every segment dark
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    // Number of HEX outputs the board provides
    localparam int         MAX_DIGITS = 6;

    // Scan FSM encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        LATCH  = 2'd2
    } scan_state_t;

    // Width of a counter that must hold 0..div-1
    function automatic int cnt_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage : hex_disp_pkg
`default_nettype wire

// File: rtl/hex7seg.sv
`default_nettype none
// ============================================================================
//  Module      : hex7seg
//  Description : Nibble to seven-segment decoder, active-low, bit 6 = seg g,
//                bit 0 = seg a.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex7seg (
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    // Pure lookup of the segment pattern for each hex value
    always_comb begin
        o_seg = 7'h7F;
        case (i_hex)
            4'h0:    o_seg = 7'h40;
            4'h1:    o_seg = 7'h79;
            4'h2:    o_seg = 7'h24;
            4'h3:    o_seg = 7'h30;
            4'h4:    o_seg = 7'h19;
            4'h5:    o_seg = 7'h12;
            4'h6:    o_seg = 7'h02;
            4'h7:    o_seg = 7'h78;
            4'h8:    o_seg = 7'h00;
            4'h9:    o_seg = 7'h10;
            4'hA:    o_seg = 7'h08;
            4'hB:    o_seg = 7'h03;
            4'hC:    o_seg = 7'h46;
            4'hD:    o_seg = 7'h21;
            4'hE:    o_seg = 7'h06;
            4'hF:    o_seg = 7'h0E;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule : hex7seg
`default_nettype wire

// File: rtl/hex_display_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : hex_display_sequencer
//  Description : Time-shares a single hex7seg decoder across up to six HEX
//                outputs. A round-robin scan FSM visits one digit per scan
//                slot, decodes it and latches the pattern into that digit's
//                registered output.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_display_sequencer
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int SCAN_DIV   = 50000
) (
    input  logic       CLOCK_50,
    input  logic       RST,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [5:0] blank_mask,
    input  logic       scan_en,
    output logic       sweep_done,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    localparam int                 CNT_W      = cnt_width(SCAN_DIV);
    localparam logic [CNT_W-1:0]   c_cnt_last = CNT_W'(SCAN_DIV - 1);
    localparam logic [2:0]         c_ptr_last = 3'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;
    scan_state_t      r_state;
    scan_state_t      w_state_next;
    logic             w_sel_load;
    logic             w_latch;
    logic             w_sweep_done;
    logic [2:0]       r_ptr;
    logic [3:0]       r_dec_in;
    logic             r_blank;
    logic [6:0]       w_seg;
    logic [3:0]       w_digit [MAX_DIGITS];
    logic [6:0]       w_hex   [MAX_DIGITS];

    // Scan slot timer: free-runs while enabled, freezes in place otherwise
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (scan_en) begin
            r_cnt <= (r_cnt == c_cnt_last) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // Gated so a counter frozen on its last value cannot re-trigger the scan
    assign w_tick = scan_en && (r_cnt == c_cnt_last);

    // FSM state register
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and per-state strobes; SELECT and LATCH always run to
    // completion once a tick has started a slot
    always_comb begin
        w_state_next = r_state;
        w_sel_load   = 1'b0;
        w_latch      = 1'b0;
        w_sweep_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_tick) begin
                    w_state_next = SELECT;
                end
            end
            SELECT: begin
                w_sel_load   = 1'b1;
                w_state_next = LATCH;
            end
            LATCH: begin
                w_latch      = 1'b1;
                w_sweep_done = (r_ptr == c_ptr_last);
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign sweep_done = w_sweep_done;

    // Decoder input, blank flag and digit pointer; SELECT samples the digit
    // register before any same-edge write lands
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            r_dec_in <= 4'h0;
            r_blank  <= 1'b0;
            r_ptr    <= 3'd0;
        end else begin
            if (w_sel_load) begin
                r_dec_in <= w_digit[r_ptr];
                r_blank  <= blank_mask[r_ptr];
            end
            if (w_latch) begin
                r_ptr <= (r_ptr == c_ptr_last) ? 3'd0 : r_ptr + 3'd1;
            end
        end
    end

    hex7seg u_hex7seg (
        .i_hex (r_dec_in),
        .o_seg (w_seg)
    );

    // Per-digit storage and output register; slots beyond NUM_DIGITS have
    // no storage, so writes addressed there simply find nothing to update
    generate
        for (genvar i = 0; i < MAX_DIGITS; i++) begin : g_digit
            if (i < NUM_DIGITS) begin : g_live
                logic [3:0] r_digit;
                logic [6:0] r_hex;

                // Nibble register written from the upstream write port
                always_ff @(posedge CLOCK_50 or posedge RST) begin
                    if (RST) begin
                        r_digit <= 4'h0;
                    end else if (wr_en && (wr_addr == 3'(i))) begin
                        r_digit <= wr_data;
                    end
                end

                // Segment register updated only when the scan lands here
                always_ff @(posedge CLOCK_50 or posedge RST) begin
                    if (RST) begin
                        r_hex <= SEG_BLANK;
                    end else if (w_latch && (r_ptr == 3'(i))) begin
                        r_hex <= r_blank ? SEG_BLANK : w_seg;
                    end
                end

                assign w_digit[i] = r_digit;
                assign w_hex[i]   = r_hex;
            end else begin : g_unused
                assign w_digit[i] = 4'h0;
                assign w_hex[i]   = SEG_BLANK;
            end
        end
    endgenerate

    assign HEX0 = w_hex[0];
    assign HEX1 = w_hex[1];
    assign HEX2 = w_hex[2];
    assign HEX3 = w_hex[3];
    assign HEX4 = w_hex[4];
    assign HEX5 = w_hex[5];

endmodule : hex_display_sequencer
`default_nettype wire

// File: doc/hex_display_sequencer.md
Name: hex_display_sequencer

Overview:
- Time-shares one hex7seg decoder across six HEX digits, so the board drives HEX0..HEX5 from a small digit register file instead of six decoder instances.
- Upstream logic writes nibbles through a simple write port.
- A round-robin scan FSM decodes one digit per scan slot and latches the segment pattern into that digit's output register.
- Sits between user/datapath logic and the board HEX pins.

Parameters:
- NUM_DIGITS, 6, number of digit slots and HEX outputs in use (1..6); unused HEX outputs stay blank.
- SCAN_DIV, 50000, CLOCK_50 cycles per scan slot (>= 3).

Ports:
- CLOCK_50  input  1  system clock
- RST  input  1  asynchronous, active-high reset
- wr_en  input  1  write strobe for the digit register file
- wr_addr  input  3  digit index to write (0 = HEX0)
- wr_data  input  4  nibble value to write
- blank_mask  input  6  bit i = 1 forces HEXi blank at its next latch
- scan_en  input  1  enables the scan tick counter
- sweep_done  output  1  one-cycle pulse when the last digit of a sweep is latched
- HEX0..HEX5  output  7 each  registered segment outputs, active-low

Behaviour:
- Reset (async, RST = 1):
  - digit registers = 4'h0
  - HEX0..HEX5 = 7'h7F (all segments off)
  - digit pointer ptr = 0, tick counter = 0, FSM = IDLE, sweep_done = 0, decoder input register dec_in = 4'h0
- Write port:
  - on a rising edge with wr_en = 1 and wr_addr < NUM_DIGITS, digit[wr_addr] <= wr_data
  - a write with wr_addr >= NUM_DIGITS is silently ignored
  - writes are accepted in every FSM state; there is no backpressure
- Tick counter:
  - when scan_en = 1, counts 0..SCAN_DIV-1 and wraps
  - tick = 1 for one cycle when count == SCAN_DIV-1
  - when scan_en = 0, the counter holds its value
- FSM states:
  - IDLE: on tick -> SELECT
  - SELECT: dec_in <= digit[ptr]; latch blank bit <= blank_mask[ptr]; -> LATCH
  - LATCH: HEX[ptr] <= latched blank ? 7'h7F : hex7seg(dec_in)
    - if ptr == NUM_DIGITS-1: ptr <= 0, sweep_done = 1 this cycle
    - else ptr <= ptr+1
    - -> IDLE
- Latency:
  - tick to HEX update = 2 cycles (SELECT, LATCH)
  - worst case from write to visible digit = NUM_DIGITS*SCAN_DIV + 2 cycles
- Simultaneous write and SELECT on the same digit: SELECT samples the pre-write value; the new value appears on that digit's next sweep.
- scan_en dropping during SELECT: the FSM still completes LATCH, then parks in IDLE. HEX outputs hold indefinitely.
- blank_mask changes take effect only at that digit's next LATCH. Bits >= NUM_DIGITS are ignored.
- HEX outputs with index >= NUM_DIGITS are tied to 7'h7F.
- RST asserted mid-operation: everything returns to reset values immediately (async). On RST release the scan restarts at ptr = 0.
- Decoder mapping is the existing hex7seg, active-low:
  - 0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00, A -> 7'h08, F -> 7'h0E

Decomposition:
- Package hex_disp_pkg holds:
  - SEG_BLANK = 7'h7F
  - MAX_DIGITS = 6
  - FSM state encoding (IDLE, SELECT, LATCH)
  - counter width derived from SCAN_DIV via $clog2
- Sub-module: exactly one instance of the existing hex7seg, inputs dec_in and output to the LATCH mux.
- Tick counter and FSM stay inline.

Test Plan (SCAN_DIV = 4, NUM_DIGITS = 6):
- Reset check: assert RST mid-scan -> all HEX = 7'h7F, sweep_done = 0 immediately. After release, the first latch goes to HEX0 at cycle 4+2.
- Full sweep: write digits 0..5 = 1,2,3,4,5,A with scan_en = 1, blank_mask = 0.
  - after 6 ticks: HEX0 = 7'h79 ... HEX5 = 7'h08
  - sweep_done pulses exactly once, at the HEX5 latch
- Blanking: set blank_mask = 6'b000100 after a sweep -> HEX2 becomes 7'h7F at its next latch; the other digits are unchanged.
- Collision: write digit[3] = F in the same cycle as SELECT of ptr = 3 -> HEX3 keeps the old value this sweep and shows 7'h0E after the next sweep.
- Pause: drop scan_en during SELECT -> LATCH still completes, then the counter and HEX hold for 100 cycles. Re-enable -> the scan resumes at the next ptr.
- Illegal address: wr_addr = 6 or 7 with wr_en = 1 -> no digit register changes; HEX values are identical across the following sweep.
